// File: rtl/sram_req_ctrl.sv
// Request-side controller for a single-port SRAM macro: turns a valid/ready request stream into
// macro pin activity and returns read data through a 2-entry response buffer with a latency-1 bypass.
module sram_req_ctrl #(
  parameter int unsigned NUM_WORD = 512,
  parameter int unsigned NUM_BIT  = 32,
  localparam int unsigned ADDR_W  = $clog2(NUM_WORD)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               scan_en_in,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic               req_we_i,
  input  logic [ADDR_W-1:0]  req_addr_i,
  input  logic [NUM_BIT-1:0] req_wdata_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [NUM_BIT-1:0] rsp_rdata_o,
  output logic               sram_ceb_o,
  output logic               sram_web_o,
  output logic [ADDR_W-1:0]  sram_a_o,
  output logic [NUM_BIT-1:0] sram_d_o,
  input  logic [NUM_BIT-1:0] sram_q_i,
  output logic               busy_o
);

  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 2;
  localparam int unsigned CRD_W = 3;

  logic               rd_pend;
  logic [CNT_W-1:0]   cnt;
  logic               wr_ptr;
  logic               rd_ptr;
  logic [NUM_BIT-1:0] rsp_buf [DEPTH];

  logic               fire;
  logic               buf_empty;
  logic               rsp_fire;
  logic               push;
  logic               pop;
  logic [CRD_W-1:0]   credits_used;

  // Credits count every read not yet handed to the consumer; a same-cycle pop does not free one.
  always_comb begin
    credits_used = CRD_W'(cnt) + CRD_W'(rd_pend);
    buf_empty    = (cnt == '0);
    req_ready_o  = ~RST & ~scan_en_in & (credits_used < CRD_W'(DEPTH));
    fire         = req_valid_i & req_ready_o;
  end

  // SRAM pins follow the accepted request in the same cycle; idle pins are parked at a known value.
  always_comb begin
    sram_ceb_o = 1'b1;
    sram_web_o = 1'b1;
    sram_a_o   = '0;
    sram_d_o   = '0;
    if (fire) begin
      sram_ceb_o = 1'b0;
      sram_web_o = ~req_we_i;
      sram_a_o   = req_addr_i;
      sram_d_o   = req_wdata_i;
    end
  end

  // Empty buffer lets the fresh Q bypass straight out; otherwise the oldest buffered word leads.
  always_comb begin
    rsp_valid_o = ~RST & (rd_pend | ~buf_empty);
    rsp_rdata_o = buf_empty ? sram_q_i : rsp_buf[rd_ptr];
    busy_o      = ~RST & (rd_pend | ~buf_empty);
    rsp_fire    = rsp_valid_o & rsp_ready_i;
    pop         = rsp_fire & ~buf_empty;
    push        = rd_pend & ~(buf_empty & rsp_ready_i);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_pend <= 1'b0;
      cnt     <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
    end else begin
      rd_pend <= fire & ~req_we_i;
      cnt     <= cnt + CNT_W'(push) - CNT_W'(pop);
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
    end
  end

  // Data storage needs no reset; occupancy alone decides what is visible.
  always_ff @(posedge CLK) begin
    if (push) begin
      rsp_buf[wr_ptr] <= sram_q_i;
    end
  end

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Bench for sram_req_ctrl: SRAM macro model on the pins, queue-based reference of outstanding reads,
// directed scenarios followed by randomized mixed traffic.
module tb_sram_req_ctrl;

  localparam int unsigned AW = 9;
  localparam int unsigned DW = 32;
  localparam int LIT_NONE  = 0;
  localparam int LIT_READY = 1;
  localparam int LIT_RDATA = 2;
  localparam int LIT_BUSY  = 3;

  logic          CLK = 1'b0;
  logic          RST;
  logic          scan_en_in;
  logic          req_valid_i;
  logic          req_ready_o;
  logic          req_we_i;
  logic [AW-1:0] req_addr_i;
  logic [DW-1:0] req_wdata_i;
  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic [DW-1:0] rsp_rdata_o;
  logic          sram_ceb_o;
  logic          sram_web_o;
  logic [AW-1:0] sram_a_o;
  logic [DW-1:0] sram_d_o;
  logic [DW-1:0] sram_q_i = '0;
  logic          busy_o;

  int n_vec = 0;
  int n_err = 0;
  int lit_kind = LIT_NONE;
  logic [DW-1:0] lit_val = '0;

  logic [DW-1:0] sram_arr [int];
  logic [DW-1:0] ref_mem  [int];
  logic [DW-1:0] exp_q    [$];

  sram_req_ctrl dut (
    .CLK(CLK), .RST(RST), .scan_en_in(scan_en_in),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .sram_ceb_o(sram_ceb_o), .sram_web_o(sram_web_o), .sram_a_o(sram_a_o),
    .sram_d_o(sram_d_o), .sram_q_i(sram_q_i), .busy_o(busy_o)
  );

  always #5 CLK = ~CLK;

  function automatic logic [DW-1:0] init_val(input int a);
    return 32'hA500_0000 ^ (32'(a) * 32'h0001_0101);
  endfunction

  // Macro model: write on CEB=0/WEB=0, Q updated on the edge of a read and held otherwise.
  always @(posedge CLK) begin
    if (!sram_ceb_o) begin
      if (!sram_web_o) sram_arr[int'(sram_a_o)] = sram_d_o;
      else sram_q_i <= sram_arr.exists(int'(sram_a_o)) ? sram_arr[int'(sram_a_o)]
                                                       : init_val(int'(sram_a_o));
    end
  end

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic lit(input int kind, input logic [DW-1:0] v);
    lit_kind = kind;
    lit_val  = v;
  endtask

  // One clock: compare at the falling edge, then advance the reference at the rising edge.
  task automatic cycle(output bit fired);
    bit rdy_e, val_e, fire_e;
    int a;
    @(negedge CLK);
    a      = int'(req_addr_i);
    rdy_e  = !RST && !scan_en_in && (exp_q.size() < 2);
    val_e  = !RST && (exp_q.size() > 0);
    fire_e = req_valid_i && rdy_e;
    fired  = req_valid_i && req_ready_o;
    chk("req_ready", 32'(req_ready_o), 32'(rdy_e));
    chk("rsp_valid", 32'(rsp_valid_o), 32'(val_e));
    chk("busy", 32'(busy_o), 32'(val_e));
    if (val_e) chk("rsp_rdata", rsp_rdata_o, exp_q[0]);
    chk("sram_ceb", 32'(sram_ceb_o), 32'(!fire_e));
    chk("sram_web", 32'(sram_web_o), 32'(fire_e ? !req_we_i : 1'b1));
    chk("sram_a", 32'(sram_a_o), fire_e ? 32'(req_addr_i) : 32'd0);
    chk("sram_d", sram_d_o, fire_e ? req_wdata_i : 32'd0);
    case (lit_kind)
      LIT_READY: chk("lit_ready", 32'(req_ready_o), 32'(lit_val[0]));
      LIT_RDATA: begin
        chk("lit_valid", 32'(rsp_valid_o), 32'd1);
        chk("lit_rdata", rsp_rdata_o, lit_val);
      end
      LIT_BUSY: begin
        chk("lit_busy", 32'(busy_o), 32'(lit_val[0]));
        chk("lit_valid0", 32'(rsp_valid_o), 32'd0);
      end
      default: ;
    endcase
    @(posedge CLK);
    if (RST) exp_q.delete();
    else begin
      if (val_e && rsp_ready_i) void'(exp_q.pop_front());
      if (fire_e) begin
        if (req_we_i) ref_mem[a] = req_wdata_i;
        else exp_q.push_back(ref_mem.exists(a) ? ref_mem[a] : init_val(a));
      end
    end
    lit_kind = LIT_NONE;
    #1;
  endtask

  task automatic req(input bit v, input bit we, input int a, input logic [DW-1:0] d);
    req_valid_i = v;
    req_we_i    = we;
    req_addr_i  = AW'(a);
    req_wdata_i = d;
  endtask

  initial begin
    bit f;
    RST = 1'b1; scan_en_in = 1'b0; rsp_ready_i = 1'b0;
    req(0, 0, 0, 0);

    // reset, then release
    repeat (3) cycle(f);
    RST = 1'b0;
    lit(LIT_READY, 1); cycle(f);

    // write then read back with immediate consumption
    req(1, 1, 5, 32'hDEADBEEF); cycle(f);
    rsp_ready_i = 1'b1;
    req(1, 0, 5, 0); cycle(f);
    req(0, 0, 0, 0);
    lit(LIT_RDATA, 32'hDEADBEEF); cycle(f);

    // back-pressure: third read waits for a pop, order preserved
    for (int i = 1; i <= 3; i++) begin
      req(1, 1, i, 32'h1111_0000 + 32'(i)); cycle(f);
    end
    rsp_ready_i = 1'b0;
    req(1, 0, 1, 0); cycle(f);
    req(1, 0, 2, 0); cycle(f);
    req(1, 0, 3, 0);
    lit(LIT_READY, 0); cycle(f);
    repeat (2) cycle(f);
    rsp_ready_i = 1'b1;
    lit(LIT_RDATA, 32'h1111_0001); cycle(f);
    f = 0;
    for (int i = 0; i < 8 && !f; i++) cycle(f);
    chk("third_read_issued", 32'(f), 32'd1);
    req(0, 0, 0, 0);
    repeat (3) cycle(f);

    // scan enable blocks issue; an in-flight read still returns
    scan_en_in = 1'b1;
    req(1, 0, 5, 0);
    lit(LIT_READY, 0); cycle(f);
    repeat (3) cycle(f);
    scan_en_in = 1'b0; cycle(f);
    chk("post_scan_issue", 32'(f), 32'd1);
    req(1, 0, 2, 0); cycle(f);
    scan_en_in = 1'b1;
    req(0, 0, 0, 0);
    lit(LIT_RDATA, 32'h1111_0002); cycle(f);
    cycle(f);
    scan_en_in = 1'b0;

    // reset with buffered and pending reads
    rsp_ready_i = 1'b0;
    req(1, 0, 1, 0); cycle(f);
    req(1, 0, 2, 0); cycle(f);
    req(0, 0, 0, 0);
    RST = 1'b1; cycle(f);
    lit(LIT_BUSY, 0); cycle(f);
    RST = 1'b0;
    repeat (3) cycle(f);

    // randomized mixed traffic
    for (int n = 0; n < 10000; n++) begin
      scan_en_in  = ($urandom_range(0, 19) == 0);
      rsp_ready_i = ($urandom_range(0, 3) != 0);
      req($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
          ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 511)) : int'($urandom_range(0, 15)),
          $urandom);
      cycle(f);
    end
    req(0, 0, 0, 0);
    scan_en_in = 1'b0;
    rsp_ready_i = 1'b1;
    repeat (4) cycle(f);
    chk("drained", 32'(rsp_valid_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
